hs_fifo_param: RTL and testbench

// - Parametrised successor to the team's handshake FIFO. It is a single-clock circular buffer with a four-phase req/ack handshake on both sides.
// - New over the previous generation: async active-low reset, arbitrary (non-power-of-two) DEPTH, synchronous flush, programmable almost-full/almost-empty flags and an occupancy output.
// - Sits between a producer and a consumer that both use tx_rdy/tx_done and rx_rdy/rx_done handshakes.

---
 rtl/hs_fifo_pkg.sv | 21 ++
 rtl/hs_fifo_ram.sv | 24 ++
 rtl/hs_fifo_param.sv | 141 ++++++++++++++
 tb/tb_hs_fifo_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hs_fifo_pkg.sv
// Shared types and helpers for the handshake FIFO: FSM state encodings and
// the pointer wrap rule used for arbitrary (non-power-of-two) depths.
package hs_fifo_pkg;

   typedef enum logic {
      T_IDLE,
      T_ACK
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_OFFER,
      R_DROP
   } rx_state_t;

   // Advance a circular-buffer pointer; the last slot wraps to 0.
   function automatic int next_ptr(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/hs_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module hs_fifo_ram #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 5,
   parameter int ADR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [ADR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_param.sv
// Single-clock circular FIFO with four-phase handshakes on producer and consumer
// sides, synchronous flush, registered occupancy and almost-full/empty flags.
module hs_fifo_param
   import hs_fifo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 5,
   parameter  int AF_LEVEL  = DEPTH - 1,
   parameter  int AE_LEVEL  = 1,
   localparam int ADR_WIDTH = $clog2(DEPTH),
   localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 tx_rdy,
   output logic                 tx_done,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 rx_rdy,
   input  logic                 rx_done,
   output logic [WIDTH-1:0]     out_data,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_empty,
   output logic                 almost_full,
   output logic [CNT_WIDTH-1:0] level
);

   tx_state_t            tx_state, tx_nxt;
   rx_state_t            rx_state, rx_nxt;
   logic [ADR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0] level_nxt;
   logic [WIDTH-1:0]     rd_data;
   logic                 push, pop, offer;

   hs_fifo_ram #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ADR_WIDTH(ADR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr),
      .wdata(in_data),
      .raddr(rd_ptr),
      .rdata(rd_data)
   );

   // Producer side: full is the registered flag, so a pop on the same edge
   // does not free a slot for this push.
   always_comb begin
      tx_nxt = tx_state;
      push   = 1'b0;
      case (tx_state)
         T_IDLE: if (tx_rdy && !full && !flush) begin
            push   = 1'b1;
            tx_nxt = T_ACK;
         end
         T_ACK:   if (!tx_rdy) tx_nxt = T_IDLE;
         default: tx_nxt = T_IDLE;
      endcase
   end

   always_comb begin
      rx_nxt = rx_state;
      pop    = 1'b0;
      offer  = 1'b0;
      case (rx_state)
         R_IDLE: if (!empty && !flush) begin
            offer  = 1'b1;
            rx_nxt = R_OFFER;
         end
         R_OFFER: begin
            if (flush) begin
               rx_nxt = rx_done ? R_DROP : R_IDLE;
            end else if (rx_done) begin
               pop    = 1'b1;
               rx_nxt = R_DROP;
            end
         end
         R_DROP:  if (!rx_done && !flush) rx_nxt = R_IDLE;
         default: rx_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      level_nxt = level;
      if (flush)             level_nxt = '0;
      else if (push && !pop) level_nxt = level + CNT_WIDTH'(1);
      else if (pop && !push) level_nxt = level - CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         tx_done  <= 1'b0;
      end else begin
         tx_state <= tx_nxt;
         tx_done  <= (tx_nxt == T_ACK);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= R_IDLE;
         rx_rdy   <= 1'b0;
         out_data <= '0;
      end else begin
         rx_state <= rx_nxt;
         rx_rdy   <= (rx_nxt == R_OFFER);
         if (offer) out_data <= rd_data;
      end
   end

   // Flags are derived from the next level so they stay aligned with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= (AF_LEVEL == 0);
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= ADR_WIDTH'(next_ptr(32'(wr_ptr), DEPTH));
            if (pop)  rd_ptr <= ADR_WIDTH'(next_ptr(32'(rd_ptr), DEPTH));
         end
         level        <= level_nxt;
         empty        <= (level_nxt == '0);
         full         <= (int'(level_nxt) == DEPTH);
         almost_empty <= (int'(level_nxt) <= AE_LEVEL);
         almost_full  <= (int'(level_nxt) >= AF_LEVEL);
      end
   end

endmodule

// File: tb/tb_hs_fifo_param.sv
// Directed/randomized bench for hs_fifo_param (DEPTH=5, AF=4, AE=1) against a
// queue-based reference of the FIFO contents.
module tb_hs_fifo_param;

   localparam int W = 8;
   localparam int D = 5;

   logic         clk = 1'b0;
   logic         rst_n, flush, tx_rdy, rx_done;
   logic [W-1:0] in_data;
   logic         tx_done, rx_rdy, empty, full, almost_empty, almost_full;
   logic [W-1:0] out_data;
   logic [2:0]   level;

   int           passes = 0;
   int           total  = 0;
   logic [W-1:0] q[$];
   logic [W-1:0] d;

   hs_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .tx_rdy(tx_rdy), .tx_done(tx_done), .in_data(in_data),
      .rx_rdy(rx_rdy), .rx_done(rx_done), .out_data(out_data),
      .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .level(level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_flags(input string tag);
      int n;
      n = q.size();
      chk({tag, ".level"}, 32'(level), n);
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"},  32'(full),  32'(n == D));
      chk({tag, ".ae"},    32'(almost_empty), 32'(n <= 1));
      chk({tag, ".af"},    32'(almost_full),  32'(n >= 4));
   endtask

   // Full producer handshake; the model takes the word when tx_done rises.
   task automatic push(input logic [W-1:0] v);
      int n;
      tx_rdy  = 1'b1;
      in_data = v;
      n = 0;
      tick();
      while (!tx_done && n < 20) begin tick(); n++; end
      chk("push.ack", 32'(tx_done), 1);
      q.push_back(v);
      tx_rdy = 1'b0;
      tick();
      chk("push.release", 32'(tx_done), 0);
   endtask

   // Full consumer handshake, checking the offered word against the model head.
   task automatic pop();
      int n;
      n = 0;
      while (!rx_rdy && n < 20) begin tick(); n++; end
      chk("pop.offer", 32'(rx_rdy), 1);
      chk("pop.data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'hxxxx_xxxx);
      rx_done = 1'b1;
      tick();
      chk("pop.drop", 32'(rx_rdy), 0);
      if (q.size() > 0) void'(q.pop_front());
      rx_done = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; flush = 1'b0; tx_rdy = 1'b0; rx_done = 1'b0; in_data = '0;
      tick(); tick();
      chk("rst.tx_done", 32'(tx_done), 0);
      chk("rst.rx_rdy", 32'(rx_rdy), 0);
      chk("rst.out_data", 32'(out_data), 0);
      chk_flags("rst");
      rst_n = 1'b1;
      tick();

      // First-word latency
      tx_rdy = 1'b1; in_data = 8'h3C;
      tick();
      chk("lat.tx_done", 32'(tx_done), 1);
      chk("lat.rx_rdy0", 32'(rx_rdy), 0);
      chk("lat.empty", 32'(empty), 0);
      tick();
      chk("lat.rx_rdy1", 32'(rx_rdy), 1);
      chk("lat.out_data", 32'(out_data), 32'h3C);
      q.push_back(8'h3C);
      tx_rdy = 1'b0;
      tick();
      pop();
      chk_flags("lat.after");

      // Fill to full, stalled sixth word, wrap-around reads
      for (int i = 0; i < D; i++) push(8'($urandom));
      chk_flags("fill");
      d = 8'($urandom);
      tx_rdy = 1'b1; in_data = d;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fill.stall", 32'(tx_done), 0);
      end
      pop();
      n = 0;
      while (!tx_done && n < 20) begin tick(); n++; end
      chk("fill.late_ack", 32'(tx_done), 1);
      q.push_back(d);
      tx_rdy = 1'b0;
      tick();
      chk_flags("wrap.full");
      for (int i = 0; i < D; i++) pop();
      chk_flags("wrap.drained");

      // Push and pop completing on the same edge at level 2
      push(8'($urandom));
      push(8'($urandom));
      chk("cc.offer", 32'(rx_rdy), 1);
      d = 8'($urandom);
      tx_rdy = 1'b1; in_data = d; rx_done = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(d);
      chk("cc.tx_done", 32'(tx_done), 1);
      chk("cc.rx_rdy", 32'(rx_rdy), 0);
      chk_flags("cc");
      tx_rdy = 1'b0; rx_done = 1'b0;
      tick();
      pop();
      pop();
      chk_flags("cc.drained");

      // Flush while offering
      for (int i = 0; i < 4; i++) push(8'($urandom));
      n = 0;
      while (!rx_rdy && n < 20) begin tick(); n++; end
      chk("fl.offer", 32'(rx_rdy), 1);
      chk("fl.w0", 32'(out_data), 32'(q[0]));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      q.delete();
      chk("fl.rx_rdy", 32'(rx_rdy), 0);
      chk_flags("fl");
      tick();
      chk("fl.idle", 32'(rx_rdy), 0);
      push(8'h55);
      pop();

      // Threshold sweep 0..5 and back
      chk_flags("thr0");
      for (int i = 1; i <= D; i++) begin
         push(8'($urandom));
         chk_flags("thr.up");
      end
      for (int i = 0; i < D; i++) begin
         pop();
         chk_flags("thr.down");
      end

      // Asynchronous reset mid-T_ACK with 3 words stored
      push(8'($urandom));
      push(8'($urandom));
      tx_rdy = 1'b1; in_data = 8'hA7;
      tick();
      chk("ar.pre_ack", 32'(tx_done), 1);
      chk("ar.pre_level", 32'(level), 3);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("ar.tx_done", 32'(tx_done), 0);
      chk("ar.rx_rdy", 32'(rx_rdy), 0);
      chk_flags("ar");
      #1 rst_n = 1'b1;
      tick();
      chk("ar.new_req", 32'(tx_done), 1);
      q.push_back(8'hA7);
      tx_rdy = 1'b0;
      tick();
      chk_flags("ar.after");
      pop();
      chk_flags("end");

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
